// File: rtl/com_divide_scheduler.sv
// -----------------------------------------------------------------------------
// com_divide_scheduler
//
// Purpose:
//   Shares one iterative restoring divider among N_TRACKERS centre-of-mass
//   accumulators. When a frame starts, every tracker's X sum, Y sum and pixel
//   count are captured. The block then runs 2*N_TRACKERS unsigned divisions
//   in a fixed order: tracker 0 X, tracker 0 Y, tracker 1 X, and so on.
//   All centroids are published together in a single COMMIT edge, so a
//   consumer never sees results from two different frames.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   frame_start_i  one-cycle pulse that requests a new division batch
//   sum_x_i        flattened X sums, tracker i at [i*SUM_W +: SUM_W]
//   sum_y_i        flattened Y sums, same packing as sum_x_i
//   pix_count_i    flattened pixel counts, tracker i at [i*CNT_W +: CNT_W]
//   com_x_o        published centroid X, 11 bits per tracker
//   com_y_o        published centroid Y, 10 bits per tracker
//   com_valid_o    per tracker: nonzero count in the last published batch
//   busy_o         batch in progress (LOAD/DIVIDE/STORE)
//   done_o         one-cycle pulse in the cycle the results are published
//   overrun_o      frame_start_i seen while not idle (request is dropped)
//
// N_TRACKERS must be at least 2.
// -----------------------------------------------------------------------------
module com_divide_scheduler #(
  parameter int N_TRACKERS = 2,
  parameter int SUM_W      = 28,
  parameter int CNT_W      = 21
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        frame_start_i,
  input  logic [N_TRACKERS*SUM_W-1:0] sum_x_i,
  input  logic [N_TRACKERS*SUM_W-1:0] sum_y_i,
  input  logic [N_TRACKERS*CNT_W-1:0] pix_count_i,
  output logic [N_TRACKERS*11-1:0]    com_x_o,
  output logic [N_TRACKERS*10-1:0]    com_y_o,
  output logic [N_TRACKERS-1:0]       com_valid_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overrun_o
);

  localparam int JOBS = 2 * N_TRACKERS;
  localparam int JW   = $clog2(JOBS);
  localparam int BW   = $clog2(SUM_W);
  localparam logic [JW-1:0] LAST_JOB = JW'(JOBS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SUM_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIVIDE,
    STORE,
    COMMIT
  } state_t;

  state_t stateQ, stateD;

  logic [N_TRACKERS*SUM_W-1:0] snapX_q, snapY_q;
  logic [N_TRACKERS*CNT_W-1:0] snapCnt_q;
  logic [N_TRACKERS*11-1:0]    shadowX_q;
  logic [N_TRACKERS*10-1:0]    shadowY_q;
  logic [N_TRACKERS-1:0]       shadowValid_q;
  logic [N_TRACKERS*11-1:0]    comX_q;
  logic [N_TRACKERS*10-1:0]    comY_q;
  logic [N_TRACKERS-1:0]       comValid_q;

  logic [JW-1:0]    jobIdx_q;
  logic [BW-1:0]    bitCnt_q;
  logic [SUM_W-1:0] quot_q;
  logic [CNT_W:0]   rem_q;
  logic [CNT_W-1:0] div_q;

  logic [JW-2:0]    trk;
  logic             isY;
  logic [SUM_W-1:0] curDividend;
  logic [CNT_W-1:0] curDivisor;
  logic [CNT_W+1:0] shifted;
  logic [CNT_W+1:0] diff;
  logic             borrow;
  logic [10:0]      satX;
  logic [9:0]       satY;

  // Job index packs tracker (upper bits) and axis (LSB: 0 = X, 1 = Y).
  assign trk = jobIdx_q[JW-1:1];
  assign isY = jobIdx_q[0];

  // Operand selection and one restoring-division step. The shifted remainder
  // is always below 2*divisor, so its top bit is zero and the MSB of the
  // difference is a reliable borrow flag.
  always_comb begin
    curDividend = isY ? snapY_q[trk*SUM_W +: SUM_W] : snapX_q[trk*SUM_W +: SUM_W];
    curDivisor  = snapCnt_q[trk*CNT_W +: CNT_W];
    shifted     = {rem_q, quot_q[SUM_W-1]};
    diff        = shifted - {2'b00, div_q};
    borrow      = diff[CNT_W+1];
    satX        = (|quot_q[SUM_W-1:11]) ? 11'h7FF : quot_q[10:0];
    satY        = (|quot_q[SUM_W-1:10]) ? 10'h3FF : quot_q[9:0];
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stateQ <= IDLE;
    else         stateQ <= stateD;
  end

  // Next-state and status outputs. A frame_start outside IDLE (COMMIT
  // included) is dropped and flagged as an overrun in the same cycle.
  always_comb begin
    stateD    = stateQ;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    overrun_o = 1'b0;
    case (stateQ)
      IDLE:   if (frame_start_i) stateD = LOAD;
      LOAD:   begin
        busy_o = 1'b1;
        stateD = DIVIDE;
      end
      DIVIDE: begin
        busy_o = 1'b1;
        if (bitCnt_q == LAST_BIT) stateD = STORE;
      end
      STORE:  begin
        busy_o = 1'b1;
        stateD = (jobIdx_q == LAST_JOB) ? COMMIT : LOAD;
      end
      COMMIT: begin
        done_o = 1'b1;
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
    if (stateQ != IDLE && frame_start_i) overrun_o = 1'b1;
  end

  // Datapath: snapshot, divider, shadow results and published outputs.
  // A zero divisor still runs the full DIVIDE length; its quotient is
  // discarded and the previously published value is carried into shadow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snapX_q       <= '0;
      snapY_q       <= '0;
      snapCnt_q     <= '0;
      shadowX_q     <= '0;
      shadowY_q     <= '0;
      shadowValid_q <= '0;
      comX_q        <= '0;
      comY_q        <= '0;
      comValid_q    <= '0;
      jobIdx_q      <= '0;
      bitCnt_q      <= '0;
      quot_q        <= '0;
      rem_q         <= '0;
      div_q         <= '0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (frame_start_i) begin
            snapX_q   <= sum_x_i;
            snapY_q   <= sum_y_i;
            snapCnt_q <= pix_count_i;
            jobIdx_q  <= '0;
          end
        end
        LOAD: begin
          quot_q   <= curDividend;
          rem_q    <= '0;
          div_q    <= curDivisor;
          bitCnt_q <= '0;
        end
        DIVIDE: begin
          quot_q   <= {quot_q[SUM_W-2:0], ~borrow};
          rem_q    <= borrow ? shifted[CNT_W:0] : diff[CNT_W:0];
          bitCnt_q <= bitCnt_q + 1'b1;
        end
        STORE: begin
          if (div_q == '0) begin
            if (isY) shadowY_q[trk*10 +: 10] <= comY_q[trk*10 +: 10];
            else     shadowX_q[trk*11 +: 11] <= comX_q[trk*11 +: 11];
            shadowValid_q[trk] <= 1'b0;
          end else begin
            if (isY) shadowY_q[trk*10 +: 10] <= satY;
            else     shadowX_q[trk*11 +: 11] <= satX;
            shadowValid_q[trk] <= 1'b1;
          end
          jobIdx_q <= (jobIdx_q == LAST_JOB) ? '0 : jobIdx_q + 1'b1;
        end
        COMMIT: begin
          comX_q     <= shadowX_q;
          comY_q     <= shadowY_q;
          comValid_q <= shadowValid_q;
        end
        default: ;
      endcase
    end
  end

  assign com_x_o     = comX_q;
  assign com_y_o     = comY_q;
  assign com_valid_o = comValid_q;

endmodule
